spi_seg_display_n: RTL and testbench
====================================

Name: spi_seg_display_n

Overview:
Parametrised SPI driver for an N-digit 7-segment display module; successor to the fixed 4-digit display driver.
- Latches packed 4-bit digit codes and encodes each one per a 2-bit mode.
- Streams one 16-bit SPI frame per digit ({address byte, segment byte}, MSB first, SPI mode 0).
- Reports busy/done and captures the last MISO frame.
- Sits between the front-panel/control logic and the external display SPI pins.

Parameters:
NUM_DIGITS, 8, number of digits/frames per refresh (1..15)
CLK_DIV, 4, clk cycles per SCLK half-period (>=1)
ADDR_BASE, 8'h01, address byte of digit 0; digit i uses ADDR_BASE+i
BLANK_CODE, 4'hF, digit code shown blank in mode 0

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
set  input  1  capture din into shadow register
din  input  4*NUM_DIGITS  digit codes, digit i at [4i+3:4i]
start  input  1  refresh request (rising-edge detected)
mode  input  2  encoding mode, sampled at start acceptance
busy  output  1  refresh in progress
done  output  1  one-cycle pulse at refresh completion
ss  output  1  SPI slave select, active low
mosi  output  1  SPI data out
miso  input  1  SPI data in
sclk  output  1  SPI clock, idle low
rx_data  output  16  last complete frame shifted in on miso
state  output  3  current FSM state encoding (debug)

Behaviour:
- Reset (rst low, async):
  - Outputs: ss=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0, state=IDLE.
  - Internal: shadow=0, start edge register=0.
  - Abort mid-frame is immediate; no partial frame resumes.
- set:
  - When busy=0, shadow<=din on that edge.
  - When busy=1, set is ignored.
  - set and start in the same cycle: the frame uses the newly captured value.
- start:
  - Accepted on a 0->1 edge only while in IDLE; latches mode.
  - A held-high start gives exactly one refresh. Edges while busy are dropped.
- FSM (IDLE, LOAD, ASSERT, SHIFT, DEASSERT, DONE):
  - IDLE: on accepted start -> LOAD; busy=1 from the next cycle; digit index=0.
  - LOAD (1 cycle): frame={ADDR_BASE+idx, seg(idx)} -> ASSERT.
  - ASSERT (CLK_DIV cycles): ss=0, sclk=0, mosi=frame[15] -> SHIFT.
  - SHIFT (32*CLK_DIV cycles, 16 bits): each bit has sclk low for CLK_DIV cycles, then high for CLK_DIV. mosi changes only while sclk low (at bit start). miso is sampled on the clk edge that drives sclk high. After bit 0 (LSB), sclk=0, rx_data<=shifted word -> DEASSERT.
  - DEASSERT (CLK_DIV cycles): ss=1. If idx<NUM_DIGITS-1: idx++, -> LOAD. Else -> DONE.
  - DONE (1 cycle): done=1, busy=0 -> IDLE.
- Timing:
  - Each frame takes 34*CLK_DIV+1 cycles.
  - A refresh takes NUM_DIGITS*(34*CLK_DIV+1)+1 cycles from start acceptance to the done pulse.
  - ss low at start-edge cycle +2.
- Segment byte {dp,g,f,e,d,c,b,a}:
  - mode 0: hex encode; code==BLANK_CODE -> 8'h00.
  - mode 1: lamp test, 8'hFF for every digit.
  - mode 2: full hex; F -> 8'h71.
  - mode 3: all 8'h00 (blank/shutdown).
  - Hex table includes 0->3F, 1->06, 2->5B, 3->4F, 5->6D, 6->7D, 8->7F, 9->6F, A->77, B->7C.
- Address byte wraps modulo 256.

Decomposition:
- Package spi_seg_pkg holds:
  - state encodings (IDLE=0 .. DONE=5);
  - mode constants MODE_HEXBLANK/MODE_TEST/MODE_HEX/MODE_OFF;
  - SEG_BLANK=8'h00, SEG_ALL=8'hFF;
  - FRAME_W=16.
- Sub-module seg7_encode (combinational: code[3:0], mode[1:0] -> seg[7:0]) is instantiated once. It is indexed by the current digit.

Test Plan:
- Reset mid-SHIFT: rst low -> ss=1, sclk=0, busy=0 asynchronously; next start gives a clean full refresh.
- NUM_DIGITS=4, CLK_DIV=4, din={3,F,F,F}, mode 0, set+start -> frames 0100,0200,0300,044F; done 549 cycles after acceptance.
- mode 1 with any din -> every segment byte FF. mode 3 -> every segment byte 00. mode 2, din={9,6,5,8} -> 017F,026D,037D,046F.
- start held high 3000 cycles -> exactly one done pulse. Second start edge during busy -> ignored. set during busy -> shadow unchanged.
- MISO loopback (miso=mosi) with CLK_DIV=1 -> rx_data equals last frame sent. SCLK period is 2 clk. ss is high for >=1 cycle between frames.
- NUM_DIGITS=8, ADDR_BASE=8'hFE -> digit address bytes FE,FF,00,01,... (wrap).

Source files
------------

// File: rtl/spi_seg_pkg.sv
// Shared constants for the N-digit SPI 7-segment display driver: FSM encodings,
// encoding modes, fixed segment patterns and the hex glyph table.
package spi_seg_pkg;

  localparam int FRAME_W = 16;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_ASSERT   = 3'd2;
  localparam logic [2:0] ST_SHIFT    = 3'd3;
  localparam logic [2:0] ST_DEASSERT = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  localparam logic [1:0] MODE_HEXBLANK = 2'd0;
  localparam logic [1:0] MODE_TEST     = 2'd1;
  localparam logic [1:0] MODE_HEX      = 2'd2;
  localparam logic [1:0] MODE_OFF      = 2'd3;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_ALL   = 8'hFF;

  // Segment byte is {dp,g,f,e,d,c,b,a}; dp is never lit by the hex glyphs.
  function automatic logic [7:0] hex_seg(input logic [3:0] code);
    logic [7:0] s;
    case (code)
      4'h0: s = 8'h3F;
      4'h1: s = 8'h06;
      4'h2: s = 8'h5B;
      4'h3: s = 8'h4F;
      4'h4: s = 8'h66;
      4'h5: s = 8'h6D;
      4'h6: s = 8'h7D;
      4'h7: s = 8'h07;
      4'h8: s = 8'h7F;
      4'h9: s = 8'h6F;
      4'hA: s = 8'h77;
      4'hB: s = 8'h7C;
      4'hC: s = 8'h39;
      4'hD: s = 8'h5E;
      4'hE: s = 8'h79;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational digit-code to segment-byte encoder, selected by display mode.
module seg7_encode
  import spi_seg_pkg::*;
#(
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input  logic [3:0] code,
  input  logic [1:0] mode,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (mode)
      MODE_HEXBLANK: seg = (code == BLANK_CODE) ? SEG_BLANK : hex_seg(code);
      MODE_TEST:     seg = SEG_ALL;
      MODE_HEX:      seg = hex_seg(code);
      default:       seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/spi_seg_display_n.sv
// SPI mode-0 driver for an N-digit 7-segment module: one {address, segment}
// frame per digit, MSB first, with the last MISO word kept in rx_data.
module spi_seg_display_n
  import spi_seg_pkg::*;
#(
  parameter int         NUM_DIGITS = 8,
  parameter int         CLK_DIV    = 4,
  parameter logic [7:0] ADDR_BASE  = 8'h01,
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    set,
  input  logic [4*NUM_DIGITS-1:0] din,
  input  logic                    start,
  input  logic [1:0]              mode,
  output logic                    busy,
  output logic                    done,
  output logic                    ss,
  output logic                    mosi,
  input  logic                    miso,
  output logic                    sclk,
  output logic [FRAME_W-1:0]      rx_data,
  output logic [2:0]              state
);

  localparam int             DW       = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [3:0]     IDX_LAST = 4'(NUM_DIGITS - 1);

  // Request protocol: a 0->1 edge on start seen in IDLE is accepted; busy is
  // high from the next cycle until the single-cycle done pulse, and any start
  // edge or set seen while busy is discarded rather than queued.
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    start_q;
  logic [1:0]              mode_q;
  logic [3:0]              idx;
  logic [DW-1:0]           div_cnt;
  logic [4:0]              hcnt;
  logic [14:0]             tx_sr;
  logic [15:0]             rx_sr;
  logic [3:0]              code;
  logic [7:0]              seg;
  logic [7:0]              addr;
  logic                    div_end;

  assign div_end = (div_cnt == DIV_LAST);
  assign busy    = (state != ST_IDLE) && (state != ST_DONE);
  assign done    = (state == ST_DONE);
  assign addr    = ADDR_BASE + {4'h0, idx};

  always_comb begin
    code = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == 4'(i)) code = shadow[4*i +: 4];
    end
  end

  seg7_encode #(.BLANK_CODE(BLANK_CODE)) u_enc (
    .code (code),
    .mode (mode_q),
    .seg  (seg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow  <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= start;
      if (set && !busy) shadow <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      mode_q  <= MODE_HEXBLANK;
      idx     <= 4'h0;
      div_cnt <= '0;
      hcnt    <= 5'd0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_data <= '0;
      ss      <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !start_q) begin
            mode_q <= mode;
            idx    <= 4'h0;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          mosi    <= addr[7];
          tx_sr   <= {addr[6:0], seg};
          ss      <= 1'b0;
          div_cnt <= '0;
          state   <= ST_ASSERT;
        end
        ST_ASSERT: begin
          if (div_end) begin
            div_cnt <= '0;
            hcnt    <= 5'd0;
            state   <= ST_SHIFT;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          // Even half-periods are sclk low, odd ones sclk high.
          if (div_end) begin
            div_cnt <= '0;
            if (!hcnt[0]) begin
              sclk  <= 1'b1;
              rx_sr <= {rx_sr[14:0], miso};
              hcnt  <= hcnt + 5'd1;
            end else if (hcnt == 5'd31) begin
              sclk    <= 1'b0;
              mosi    <= 1'b0;
              ss      <= 1'b1;
              rx_data <= rx_sr;
              state   <= ST_DEASSERT;
            end else begin
              sclk  <= 1'b0;
              mosi  <= tx_sr[14];
              tx_sr <= {tx_sr[13:0], 1'b0};
              hcnt  <= hcnt + 5'd1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_DEASSERT: begin
          if (div_end) begin
            div_cnt <= '0;
            if (idx == IDX_LAST) begin
              state <= ST_DONE;
            end else begin
              idx   <= idx + 4'd1;
              state <= ST_LOAD;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_seg_display_n.sv
// Bench for spi_seg_display_n: two configurations, a slave-side frame monitor
// per instance, and a reference model built from the display encoding rules.
module tb_spi_seg_display_n;

  localparam int         NA = 4;
  localparam int         CA = 4;
  localparam logic [7:0] BA = 8'h01;
  localparam int         NB = 8;
  localparam int         CB = 1;
  localparam logic [7:0] BB = 8'hFE;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        set_a = 0, start_a = 0, busy_a, done_a, ss_a, mosi_a, miso_a, sclk_a;
  logic [15:0] din_a = '0, rx_a;
  logic [1:0]  mode_a = '0;
  logic [2:0]  state_a;
  logic        set_b = 0, start_b = 0, busy_b, done_b, ss_b, mosi_b, miso_b, sclk_b;
  logic [31:0] din_b = '0;
  logic [15:0] rx_b;
  logic [1:0]  mode_b = '0;
  logic [2:0]  state_b;

  assign miso_a = ~mosi_a;
  assign miso_b = mosi_b;

  spi_seg_display_n #(.NUM_DIGITS(NA), .CLK_DIV(CA), .ADDR_BASE(BA), .BLANK_CODE(4'hF)) dut_a (
    .clk(clk), .rst(rst), .set(set_a), .din(din_a), .start(start_a), .mode(mode_a),
    .busy(busy_a), .done(done_a), .ss(ss_a), .mosi(mosi_a), .miso(miso_a), .sclk(sclk_a),
    .rx_data(rx_a), .state(state_a));

  spi_seg_display_n #(.NUM_DIGITS(NB), .CLK_DIV(CB), .ADDR_BASE(BB), .BLANK_CODE(4'hF)) dut_b (
    .clk(clk), .rst(rst), .set(set_b), .din(din_b), .start(start_b), .mode(mode_b),
    .busy(busy_b), .done(done_b), .ss(ss_b), .mosi(mosi_b), .miso(miso_b), .sclk(sclk_b),
    .rx_data(rx_b), .state(state_b));

  int tests = 0;
  int fails = 0;

  logic [7:0]  hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  logic [15:0] exp_q[$];
  logic [15:0] cap_a[$];
  logic [15:0] cap_b[$];

  // Slave-side monitors: sample mosi on rising sclk, commit a frame on ss rise.
  logic [15:0] sh_a = '0, sh_b = '0;
  int          nb_a = 0, nb_b = 0, per_err = 0;
  time         last_b = 0;

  always @(posedge sclk_a) if (ss_a === 1'b0) begin sh_a = {sh_a[14:0], mosi_a}; nb_a++; end
  always @(posedge ss_a) begin if (nb_a == 16) cap_a.push_back(sh_a); nb_a = 0; end
  always @(posedge sclk_b) if (ss_b === 1'b0) begin
    if (nb_b > 0 && ($time - last_b) != 20) per_err++;
    last_b = $time;
    sh_b = {sh_b[14:0], mosi_b};
    nb_b++;
  end
  always @(posedge ss_b) begin if (nb_b == 16) cap_b.push_back(sh_b); nb_b = 0; end

  task automatic build_exp(input bit which, input logic [31:0] d, input logic [1:0] m);
    int         nd   = which ? NB : NA;
    logic [7:0] base = which ? BB : BA;
    logic [3:0] c;
    logic [7:0] s;
    exp_q.delete();
    for (int i = 0; i < nd; i++) begin
      c = d[4*i +: 4];
      case (m)
        2'd0:    s = (c == 4'hF) ? 8'h00 : hex_tab[c];
        2'd1:    s = 8'hFF;
        2'd2:    s = hex_tab[c];
        default: s = 8'h00;
      endcase
      exp_q.push_back({base + 8'(i), s});
    end
  endtask

  // Drives one refresh request and measures it; lat is -1 if done never came.
  task automatic refresh(input bit which, input logic [31:0] d, input logic [1:0] m,
                         input bit do_set, output int lat, output logic ss2, output int ssb);
    cap_a.delete();
    cap_b.delete();
    @(negedge clk);
    if (which) begin din_b = d; mode_b = m; set_b = do_set; start_b = 1'b1; end
    else begin din_a = d[15:0]; mode_a = m; set_a = do_set; start_a = 1'b1; end
    lat = -1; ss2 = 1'bx; ssb = 0;
    for (int n = 1; n <= 4000; n++) begin
      @(negedge clk);
      if (n == 1) begin set_a = 1'b0; set_b = 1'b0; end
      if (n == 2) ss2 = which ? ss_b : ss_a;
      if ((which ? busy_b : busy_a) && (which ? ss_b : ss_a)) ssb++;
      if (which ? done_b : done_a) begin lat = n; break; end
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests++;
    if ({ss_a, sclk_a, mosi_a, busy_a, done_a, rx_a, state_a} !== {5'b10000, 16'h0, 3'd0}) begin
      fails++;
      $display("FAIL reset_a got ss=%b sclk=%b mosi=%b busy=%b done=%b rx=%h st=%0d want 1 0 0 0 0 0000 0",
               ss_a, sclk_a, mosi_a, busy_a, done_a, rx_a, state_a);
    end
    tests++;
    if ({ss_b, sclk_b, mosi_b, busy_b, done_b, rx_b, state_b} !== {5'b10000, 16'h0, 3'd0}) begin
      fails++;
      $display("FAIL reset_b got ss=%b sclk=%b busy=%b rx=%h st=%0d want 1 0 0 0000 0",
               ss_b, sclk_b, busy_b, rx_b, state_b);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (busy_a !== 1'b0 || ss_a !== 1'b1 || state_a !== 3'd0) begin
      fails++;
      $display("FAIL post_reset_idle got busy=%b ss=%b st=%0d want 0 1 0", busy_a, ss_a, state_a);
    end
  endtask

  task automatic test_hexblank;
    int lat, ssb; logic ss2;
    refresh(0, 32'h3FFF, 2'd0, 1'b1, lat, ss2, ssb);
    build_exp(0, 32'h3FFF, 2'd0);
    tests++;
    if (lat != NA * (34 * CA + 1) + 1) begin
      fails++; $display("FAIL hexblank_latency got %0d want %0d", lat, NA * (34 * CA + 1) + 1);
    end
    tests++;
    if (ss2 !== 1'b0) begin fails++; $display("FAIL ss_low_cycle2 got %b want 0", ss2); end
    @(negedge clk);
    tests++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      fails++; $display("FAIL done_one_cycle got done=%b busy=%b want 0 0", done_a, busy_a);
    end
    tests++;
    if (cap_a.size() != exp_q.size()) begin
      fails++; $display("FAIL hexblank_count got %0d want %0d", cap_a.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      tests++;
      if (cap_a[i] !== exp_q[i]) begin
        fails++; $display("FAIL hexblank_frame%0d got %h want %h", i, cap_a[i], exp_q[i]);
      end
    end
    tests++;
    if (rx_a !== ~exp_q[exp_q.size()-1]) begin
      fails++; $display("FAIL rx_inverted got %h want %h", rx_a, ~exp_q[exp_q.size()-1]);
    end
  endtask

  task automatic test_modes;
    logic [15:0] dv [3] = '{16'($urandom), 16'($urandom), 16'h9658};
    logic [1:0]  mv [3] = '{2'd1, 2'd3, 2'd2};
    int lat, ssb; logic ss2;
    for (int k = 0; k < 3; k++) begin
      refresh(0, {16'h0, dv[k]}, mv[k], 1'b1, lat, ss2, ssb);
      build_exp(0, {16'h0, dv[k]}, mv[k]);
      tests++;
      if (cap_a.size() != exp_q.size()) begin
        fails++; $display("FAIL mode%0d_count got %0d want %0d", mv[k], cap_a.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        tests++;
        if (cap_a[i] !== exp_q[i]) begin
          fails++; $display("FAIL mode%0d_frame%0d got %h want %h", mv[k], i, cap_a[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random;
    int lat, ssb; logic ss2;
    logic [31:0] d;
    logic [1:0]  m;
    bit          w;
    for (int k = 0; k < 6; k++) begin
      w = (k >= 4);
      d = $urandom;
      m = 2'($urandom_range(0, 3));
      refresh(w, d, m, 1'b1, lat, ss2, ssb);
      build_exp(w, d, m);
      tests++;
      if (lat != (w ? NB * (34 * CB + 1) + 1 : NA * (34 * CA + 1) + 1)) begin
        fails++; $display("FAIL random%0d_latency got %0d", k, lat);
      end
      tests++;
      if ((w ? cap_b.size() : cap_a.size()) != exp_q.size()) begin
        fails++; $display("FAIL random%0d_count got %0d want %0d", k, w ? cap_b.size() : cap_a.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        tests++;
        if ((w ? cap_b[i] : cap_a[i]) !== exp_q[i]) begin
          fails++; $display("FAIL random%0d_frame%0d got %h want %h", k, i, w ? cap_b[i] : cap_a[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_held_start;
    int dones = 0, lat, ssb; logic ss2;
    logic [15:0] x = 16'($urandom), y = ~x;
    cap_a.delete();
    @(negedge clk);
    din_a = x; mode_a = 2'd2; set_a = 1'b1; start_a = 1'b1;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (n == 1)   set_a = 1'b0;
      if (n == 100) begin din_a = y; set_a = 1'b1; end
      if (n == 101) set_a = 1'b0;
      if (n == 200) start_a = 1'b0;
      if (n == 210) start_a = 1'b1;
      if (done_a) dones++;
    end
    start_a = 1'b0;
    tests++;
    if (dones != 1) begin fails++; $display("FAIL held_start_dones got %0d want 1", dones); end
    build_exp(0, {16'h0, x}, 2'd2);
    tests++;
    if (cap_a.size() != exp_q.size()) begin
      fails++; $display("FAIL held_count got %0d want %0d", cap_a.size(), exp_q.size());
    end
    refresh(0, {16'h0, y}, 2'd2, 1'b0, lat, ss2, ssb);
    tests++;
    if (cap_a.size() != exp_q.size()) begin
      fails++; $display("FAIL shadow_count got %0d want %0d", cap_a.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      tests++;
      if (cap_a[i] !== exp_q[i]) begin
        fails++; $display("FAIL shadow_frame%0d got %h want %h", i, cap_a[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_loopback;
    int lat, ssb; logic ss2;
    logic [31:0] d = $urandom;
    per_err = 0;
    refresh(1, d, 2'd2, 1'b1, lat, ss2, ssb);
    build_exp(1, d, 2'd2);
    tests++;
    if (cap_b.size() != exp_q.size()) begin
      fails++; $display("FAIL wrap_count got %0d want %0d", cap_b.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      tests++;
      if (cap_b[i] !== exp_q[i]) begin
        fails++; $display("FAIL wrap_frame%0d got %h want %h", i, cap_b[i], exp_q[i]);
      end
    end
    tests++;
    if (rx_b !== exp_q[NB-1]) begin fails++; $display("FAIL loopback_rx got %h want %h", rx_b, exp_q[NB-1]); end
    tests++;
    if (per_err != 0) begin fails++; $display("FAIL sclk_period got %0d bad periods want 0", per_err); end
    tests++;
    if (ssb < NB) begin fails++; $display("FAIL ss_gap got %0d high cycles want >= %0d", ssb, NB); end
  endtask

  task automatic test_reset_mid;
    int lat, ssb; logic ss2;
    @(negedge clk);
    din_a = 16'($urandom); mode_a = 2'd0; set_a = 1'b1; start_a = 1'b1;
    @(negedge clk);
    set_a = 1'b0;
    repeat (149) @(negedge clk);
    tests++;
    if (state_a !== 3'd3) begin fails++; $display("FAIL mid_state got %0d want 3", state_a); end
    #2 rst = 1'b0; start_a = 1'b0;
    #1;
    tests++;
    if ({ss_a, sclk_a, mosi_a, busy_a, state_a} !== {4'b1000, 3'd0}) begin
      fails++;
      $display("FAIL async_abort got ss=%b sclk=%b mosi=%b busy=%b st=%0d want 1 0 0 0 0",
               ss_a, sclk_a, mosi_a, busy_a, state_a);
    end
    @(negedge clk);
    rst = 1'b1;
    refresh(0, 32'h0000_1234, 2'd2, 1'b0, lat, ss2, ssb);
    build_exp(0, 32'h0, 2'd2);
    tests++;
    if (lat != NA * (34 * CA + 1) + 1) begin
      fails++; $display("FAIL post_abort_latency got %0d want %0d", lat, NA * (34 * CA + 1) + 1);
    end
    tests++;
    if (cap_a.size() != exp_q.size()) begin
      fails++; $display("FAIL post_abort_count got %0d want %0d", cap_a.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      tests++;
      if (cap_a[i] !== exp_q[i]) begin
        fails++; $display("FAIL post_abort_frame%0d got %h want %h", i, cap_a[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_hexblank;
    test_modes;
    test_random;
    test_held_start;
    test_loopback;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
